// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812B frame sequencer: state encodings,
// GRB word layout, default timing, and the brightness channel scaler.
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_PRESENT   = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_LATCH     = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    localparam int GRB_W = 24;
    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    localparam int unsigned DEF_LATCH_CYCLES = 6000;
    localparam int unsigned DEF_FRAME_CYCLES = 1666667;

    // (c * (bright + 1)) >> 8 at 16 bits, so bright = 255 is the identity.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] bright);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, bright} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [GRB_W-1:0] scale_grb(input logic [GRB_W-1:0] w, input logic [7:0] bright);
        return {scale_chan(w[G_MSB:G_LSB], bright),
                scale_chan(w[R_MSB:R_LSB], bright),
                scale_chan(w[B_MSB:B_LSB], bright)};
    endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel handshake between the frame sequencer (master) and the bit serializer (slave).
// A word moves on a rising clock edge where pix_valid & pix_ready are both high; once
// pix_valid is raised, pix_data holds until that transfer, and valid never waits on ready.
interface ws2812_frame_sequencer_if;
    logic                          pix_valid;
    logic [ws2812_pkg::GRB_W-1:0]  pix_data;
    logic                          pix_ready;
    logic                          ser_idle;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready,
        input  ser_idle
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready,
        output ser_idle
    );
endinterface

// File: rtl/ws2812_cycle_timer.sv
// Loadable saturating cycle counter: i_load clears it to 0, it then counts up and
// parks at CYCLES-1, where o_done stays high.
module ws2812_cycle_timer #(
    parameter int unsigned CYCLES = 2
) (
    input  logic i_clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_done = (count_q == LAST);

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// WS2812B frame controller: walks the pixel ROM once per frame, hands GRB words to the
// serializer, enforces the latch gap and frame period. WS2812_BRIGHTNESS_EN adds i_bright scaling.
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = 30,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic                       i_clk,
    input  logic                       rst_n,
    input  logic                       i_en,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]                 i_bright,
`endif
    output logic [ADDR_W-1:0]          o_mem_addr,
    input  logic [GRB_W-1:0]           i_mem_data,
    ws2812_frame_sequencer_if.master   pix_if,
    output logic                       o_frame_busy,
    output logic                       o_frame_done,
    output logic [2:0]                 o_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [GRB_W-1:0]   data_q, data_d;
    logic [GRB_W-1:0]   fetch_word;
    logic               xfer;
    logic               latch_load, latch_expired;
    logic               frame_load, frame_expired;

    assign xfer = (state_q == ST_PRESENT) && pix_if.pix_ready;

`ifdef WS2812_BRIGHTNESS_EN
    assign fetch_word = scale_grb(i_mem_data, i_bright);
`else
    assign fetch_word = i_mem_data;
`endif

    ws2812_cycle_timer #(.CYCLES(LATCH_CYCLES)) u_latch_timer (
        .i_clk  (i_clk),
        .rst_n  (rst_n),
        .i_load (latch_load),
        .o_done (latch_expired)
    );

    // Free-running from each frame start; saturation makes an overrun frame's HOLD one cycle.
    ws2812_cycle_timer #(.CYCLES(FRAME_CYCLES)) u_frame_timer (
        .i_clk  (i_clk),
        .rst_n  (rst_n),
        .i_load (frame_load),
        .o_done (frame_expired)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_load = 1'b0;
        latch_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d    = ST_FETCH;
                    frame_load = 1'b1;
                end
            end
            ST_FETCH:   state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (xfer) begin
                    state_d = (addr_q == LAST_ADDR) ? ST_WAIT_IDLE : ST_FETCH;
                end
            end
            ST_WAIT_IDLE: begin
                if (pix_if.ser_idle) begin
                    state_d    = ST_LATCH;
                    latch_load = 1'b1;
                end
            end
            ST_LATCH: begin
                if (latch_expired) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (frame_expired) begin
                    if (i_en) begin
                        state_d    = ST_FETCH;
                        frame_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        case (state_q)
            ST_IDLE:  addr_d = '0;
            ST_FETCH: data_d = fetch_word;
            ST_PRESENT: begin
                if (xfer) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decode the state register directly, so reset drops valid without a clock.
    always_comb begin
        pix_if.pix_valid = (state_q == ST_PRESENT);
        o_frame_busy     = (state_q == ST_FETCH) || (state_q == ST_PRESENT) ||
                           (state_q == ST_WAIT_IDLE) || (state_q == ST_LATCH);
        o_frame_done     = (state_q == ST_LATCH) && latch_expired;
        o_state          = state_q;
    end

    assign pix_if.pix_data = data_q;
    assign o_mem_addr      = addr_q;

endmodule
